// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, pprot bit positions, default bus widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_pkg;

    // Phase sequencing shared by the requester and the slave.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // pprot bit positions.
    localparam int PROT_PRIV_BIT   = 0;
    localparam int PROT_NONSEC_BIT = 1;
    localparam int PROT_INSTR_BIT  = 2;
    localparam int PROT_W          = 3;

    // Default widths, sized for the 32-word slave memory.
    localparam int APB_ADDR_W = 5;
    localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Bundle of command, response and APB bus signals around the APB requester.
// Latency: n/a (wires only).
// Backpressure: cmd_ready gates command acceptance; pready stretches the ACCESS phase.
interface apb_master_ctrl_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();

    // Command port from the local controller.
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [PROT_W-1:0] cmd_prot;

    // Single-cycle completion port back to the local controller.
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    // APB bus.
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [PROT_W-1:0] pprot;
    logic              pready;
    logic              pslverr;
    logic [DATA_W-1:0] prdata;

    // Requester view.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata, pprot,
        input  pready, pslverr, prdata
    );

    // Environment view: local controller plus APB slave.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata, pprot,
        output pready, pslverr, prdata
    );

endinterface

// File: rtl/apb_master_ctrl.sv
// APB requester: one command at a time through SETUP/ACCESS, one-cycle response pulse.
// Latency: accept -> SETUP 1 cycle -> ACCESS until pready or timeout -> rsp_valid next edge.
// Backpressure: cmd_ready only in IDLE; pready stalls ACCESS, bounded by TIMEOUT (0 = unbounded).
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    apb_master_ctrl_if.master    bus
);

    // A zero-width counter is not legal, so the disabled-timeout build keeps one bit.
    localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    apb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [PROT_W-1:0] pprot_q, pprot_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic              cmd_ready;

    // The only combinational output; state resets to IDLE so this is high during reset.
    assign cmd_ready = (state_q == IDLE);

    // Next-state and next-output decode; everything holds unless a phase change updates it.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pprot_d       = pprot_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready) begin
                    state_d    = SETUP;
                    wait_cnt_d = '0;
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    pwrite_d   = bus.cmd_write;
                    paddr_d    = bus.cmd_addr;
                    pwdata_d   = bus.cmd_wdata;
                    pprot_d    = bus.cmd_prot;
                end
            end

            SETUP: begin
                // pready is deliberately not looked at until ACCESS.
                state_d   = ACCESS;
                penable_d = 1'b1;
            end

            ACCESS: begin
                if (bus.pready) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = bus.pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
                end else begin
                    if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    // Abort in the TIMEOUT-th stalled cycle.
                    if ((TIMEOUT > 0) && (wait_cnt_q == CNT_LAST)) begin
                        state_d       = IDLE;
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_rdata_d   = '0;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops the bus and suppresses any pending response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pprot_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pprot_q       <= pprot_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pprot       = pprot_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for the APB requester: scripted commands, behavioural APB slave, response scoreboard.
// Latency: n/a.
// Backpressure: slave wait states per scenario; slv_wait < 0 never asserts pready.
module tb_apb_master_ctrl;
    import apb_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 4;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          to;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Slave behaviour knobs.
    int   slv_wait = 0;
    bit   slv_err  = 1'b0;
    int   acc_cnt;
    bit   mem_loaded;
    logic [DW-1:0] mem [32];

    always #5 clk = ~clk;

    apb_master_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Counts stalled ACCESS cycles so pready can be delayed by slv_wait cycles.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) acc_cnt <= 0;
        else if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    // Slave memory: preloaded with 5A0000xx, written on error-free write completion.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h5A00_0000 | 32'(i);
            mem_loaded <= 1'b1;
        end else if (bus.psel && bus.penable && bus.pready && bus.pwrite && !bus.pslverr) begin
            mem[bus.paddr] <= bus.pwdata;
        end
    end

    assign bus.pready  = bus.psel && bus.penable && (slv_wait >= 0) && (acc_cnt >= slv_wait);
    assign bus.pslverr = bus.psel && bus.penable && slv_err;
    assign bus.prdata  = mem[bus.paddr];

    // Drives one command from a negedge, scrambles cmd_* after acceptance and
    // follows the transfer until rsp_valid, counting psel/penable cycles.
    task automatic run_xfer(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [2:0] p, output int psel_n, output int pen_n,
                            output bit stable, output bit got, output logic [DW-1:0] r_rdata,
                            output logic r_err, output logic r_to);
        bit accepted;
        psel_n = 0; pen_n = 0; stable = 1'b1; got = 1'b0;
        r_rdata = '0; r_err = 1'b0; r_to = 1'b0; accepted = 1'b0;
        bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_prot = p;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_ready) begin accepted = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~w; bus.cmd_addr = ~a; bus.cmd_wdata = ~d; bus.cmd_prot = ~p;
        if (accepted) begin
            for (int i = 0; i < 40; i++) begin
                if (bus.rsp_valid) begin
                    got = 1'b1;
                    r_rdata = bus.rsp_rdata; r_err = bus.rsp_err; r_to = bus.rsp_timeout;
                    break;
                end
                if (bus.psel) begin
                    psel_n++;
                    if (bus.penable) pen_n++;
                    if (bus.paddr !== a || bus.pwrite !== w || bus.pprot !== p ||
                        (w && bus.pwdata !== d)) stable = 1'b0;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready);
        end
        n_cmp++;
        if ({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.pprot} !== '0) begin
            n_bad++; $display("FAIL reset_apb: got psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h pprot=%b want all 0",
                              bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.pprot);
        end
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !== '0) begin
            n_bad++; $display("FAIL reset_rsp: got valid=%b err=%b to=%b rdata=%h want all 0",
                              bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int ps, pe; bit st, got; logic [DW-1:0] rd; logic er, tmo; exp_t e;
        slv_wait = 1; slv_err = 1'b0;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        run_xfer(1'b1, 5'h03, 32'hDEADBEEF, 3'b000, ps, pe, st, got, rd, er, tmo);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || {rd, er, tmo} !== {e.rdata, e.err, e.to}) begin
            n_bad++; $display("FAIL write_rsp: got valid=%b rdata=%h err=%b to=%b want rdata=%h err=%b to=%b",
                              got, rd, er, tmo, e.rdata, e.err, e.to);
        end
        n_cmp++;
        if (ps != 3 || pe != 2) begin
            n_bad++; $display("FAIL write_phases: got psel=%0d penable=%0d cycles want 3/2", ps, pe);
        end
        n_cmp++;
        if (!st) begin n_bad++; $display("FAIL write_stable: got unstable bus want stable"); end
        @(negedge clk);
        n_cmp++;
        if (bus.rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL write_pulse: got rsp_valid=%b one cycle later want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_readback();
        int ps, pe; bit st, got; logic [DW-1:0] rd; logic er, tmo; exp_t e;
        slv_wait = 0; slv_err = 1'b0;
        exp_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, to: 1'b0});
        run_xfer(1'b0, 5'h03, 32'h0, 3'b000, ps, pe, st, got, rd, er, tmo);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || {rd, er, tmo} !== {e.rdata, e.err, e.to}) begin
            n_bad++; $display("FAIL readback_rsp: got valid=%b rdata=%h err=%b to=%b want rdata=%h err=%b to=%b",
                              got, rd, er, tmo, e.rdata, e.err, e.to);
        end
        n_cmp++;
        if (!st || ps != 2 || pe != 1) begin
            n_bad++; $display("FAIL readback_bus: got stable=%b psel=%0d penable=%0d want 1/2/1", st, ps, pe);
        end
        slv_wait = 2;
        exp_q.push_back('{rdata: 32'h5A000007, err: 1'b0, to: 1'b0});
        run_xfer(1'b0, 5'h07, 32'h0, 3'b001, ps, pe, st, got, rd, er, tmo);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || {rd, er, tmo} !== {e.rdata, e.err, e.to} || ps != 4 || pe != 3 || !st) begin
            n_bad++; $display("FAIL read_wait2: got valid=%b rdata=%h err=%b psel=%0d penable=%0d stable=%b want rdata=%h err=0 4/3/1",
                              got, rd, er, ps, pe, st, e.rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_nonsecure();
        int ps, pe; bit st, got; logic [DW-1:0] rd; logic er, tmo; exp_t e;
        slv_wait = 0; slv_err = 1'b1;
        exp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b0});
        run_xfer(1'b0, 5'h03, 32'h0, 3'b010, ps, pe, st, got, rd, er, tmo);
        e = exp_q.pop_front();
        slv_err = 1'b0;
        n_cmp++;
        if (!got || {rd, er, tmo} !== {e.rdata, e.err, e.to}) begin
            n_bad++; $display("FAIL nonsec_rsp: got valid=%b rdata=%h err=%b to=%b want rdata=%h err=%b to=%b",
                              got, rd, er, tmo, e.rdata, e.err, e.to);
        end
        n_cmp++;
        if (!st) begin n_bad++; $display("FAIL nonsec_pprot: got bus not holding pprot=010 want held"); end
        @(negedge clk);
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b1) begin
            n_bad++; $display("FAIL nonsec_hold: got valid=%b err=%b want 0/1", bus.rsp_valid, bus.rsp_err);
        end
    endtask

    task automatic test_timeout();
        int ps, pe; bit st, got; logic [DW-1:0] rd; logic er, tmo; exp_t e;
        slv_wait = -1; slv_err = 1'b0;
        exp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b1});
        run_xfer(1'b0, 5'h05, 32'h0, 3'b000, ps, pe, st, got, rd, er, tmo);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || {rd, er, tmo} !== {e.rdata, e.err, e.to}) begin
            n_bad++; $display("FAIL timeout_rsp: got valid=%b rdata=%h err=%b to=%b want rdata=%h err=%b to=%b",
                              got, rd, er, tmo, e.rdata, e.err, e.to);
        end
        n_cmp++;
        if (pe != TO || ps != TO + 1) begin
            n_bad++; $display("FAIL timeout_len: got access=%0d psel=%0d cycles want %0d/%0d", pe, ps, TO, TO + 1);
        end
        n_cmp++;
        if (bus.psel !== 1'b0 || bus.penable !== 1'b0) begin
            n_bad++; $display("FAIL timeout_release: got psel=%b penable=%b want 0/0", bus.psel, bus.penable);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_timeout !== 1'b1) begin
            n_bad++; $display("FAIL timeout_hold: got valid=%b to=%b want 0/1", bus.rsp_valid, bus.rsp_timeout);
        end
        slv_wait = 0;
    endtask

    task automatic test_back_to_back();
        exp_t e; bit got; bit held = 1'b1;
        int ps, pe; bit st; logic [DW-1:0] rd; logic er, tmo;
        slv_wait = 0; slv_err = 1'b0;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        exp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        bus.cmd_write = 1'b1; bus.cmd_addr = 5'h01; bus.cmd_wdata = 32'h11111111;
        bus.cmd_prot = 3'b000; bus.cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_ready) break;
            @(negedge clk);
        end
        @(negedge clk);
        bus.cmd_addr = 5'h02; bus.cmd_wdata = 32'h22222222;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.rsp_valid) begin got = 1'b1; break; end
            if (bus.psel && bus.paddr !== 5'h01) held = 1'b0;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || !held || bus.cmd_ready !== 1'b1 ||
            {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== {e.rdata, e.err, e.to}) begin
            n_bad++; $display("FAIL b2b_first: got valid=%b held=%b cmd_ready=%b err=%b to=%b want 1/1/1/%b/%b",
                              got, held, bus.cmd_ready, bus.rsp_err, bus.rsp_timeout, e.err, e.to);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n_cmp++;
        if (bus.psel !== 1'b1 || bus.penable !== 1'b0 || bus.paddr !== 5'h02 || bus.pwdata !== 32'h22222222) begin
            n_bad++; $display("FAIL b2b_setup: got psel=%b penable=%b paddr=%h pwdata=%h want 1/0/02/22222222",
                              bus.psel, bus.penable, bus.paddr, bus.pwdata);
        end
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.rsp_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== {e.rdata, e.err, e.to}) begin
            n_bad++; $display("FAIL b2b_second: got valid=%b rdata=%h err=%b to=%b want rdata=%h err=%b to=%b",
                              got, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, e.rdata, e.err, e.to);
        end
        @(negedge clk);
        exp_q.push_back('{rdata: 32'h22222222, err: 1'b0, to: 1'b0});
        run_xfer(1'b0, 5'h02, 32'h0, 3'b000, ps, pe, st, got, rd, er, tmo);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || {rd, er, tmo} !== {e.rdata, e.err, e.to}) begin
            n_bad++; $display("FAIL b2b_readback: got valid=%b rdata=%h err=%b want rdata=%h err=0", got, rd, er, e.rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int ps, pe; bit st, got; logic [DW-1:0] rd; logic er, tmo; exp_t e; bit seen = 1'b0;
        slv_wait = -1; slv_err = 1'b0;
        bus.cmd_write = 1'b0; bus.cmd_addr = 5'h03; bus.cmd_wdata = '0; bus.cmd_prot = '0;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_ready) break;
            @(negedge clk);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.penable) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (!seen || bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_mid_drop: got seen=%b psel=%b penable=%b rsp_valid=%b cmd_ready=%b want 1/0/0/0/1",
                              seen, bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready);
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_mid_release: got rsp_valid=%b cmd_ready=%b want 0/1", bus.rsp_valid, bus.cmd_ready);
        end
        @(negedge clk);
        slv_wait = 0;
        exp_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, to: 1'b0});
        run_xfer(1'b0, 5'h03, 32'h0, 3'b000, ps, pe, st, got, rd, er, tmo);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || {rd, er, tmo} !== {e.rdata, e.err, e.to} || ps != 2 || pe != 1) begin
            n_bad++; $display("FAIL reset_mid_next: got valid=%b rdata=%h err=%b to=%b psel=%0d want rdata=%h err=0 to=0 psel=2",
                              got, rd, er, tmo, ps, e.rdata);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0;   bus.cmd_prot = '0;
        test_reset();
        test_write();
        test_readback();
        test_nonsecure();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
